// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared scan states and active-high segment patterns
// Purpose: state encoding for the two-digit scanner and the segment
//          constants {g,f,e,d,c,b,a} used by the decoder and the scanner.
package seg7_pkg;

  typedef enum logic [1:0] {
    S_ONES = 2'd0,
    S_GAP1 = 2'd1,
    S_TENS = 2'd2,
    S_GAP0 = 2'd3
  } state_e;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg7_scan_if.sv
// rtl/bcd_seg7_scan_if.sv - digit input and display output bundle
// Purpose: groups the digit capture inputs and the multiplexed display
//          outputs of bcd_seg7_scan.
//   load, tens, ones, blank_lz : driven by the digit source (master)
//   seg, an, frame_done        : driven by the scanner (slave)
interface bcd_seg7_scan_if;
  import seg7_pkg::*;

  logic       load;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  modport master (
    output load, tens, ones, blank_lz,
    input  seg, an, frame_done
  );

  modport slave (
    input  load, tens, ones, blank_lz,
    output seg, an, frame_done
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - BCD digit to active-high seven-segment pattern
// Purpose: combinational decode; codes 10-15 show a dash.
//   digit : 4-bit BCD input
//   seg   : {g,f,e,d,c,b,a}, 1 = segment lit
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// rtl/bcd_seg7_scan.sv - two-digit seven-segment scanner with blanking gaps
// Purpose: latches a tens/ones pair, scans ones then tens onto a shared
//          segment bus with blanked gaps between slots.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : load/tens/ones/blank_lz in, seg/an/frame_done out
module bcd_seg7_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int GAP_CYCLES     = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd_seg7_scan_if.slave bus
);

  localparam int CNT_MAX = (REFRESH_DIV > GAP_CYCLES) ? REFRESH_DIV : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SLOT_RLD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GAP_RLD  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // The first cycle after reset is already part of the ones slot.
  localparam logic [CW-1:0] BOOT_RLD = CW'(REFRESH_DIV - 2);

  localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_IDLE  = (AN_ACTIVE_LOW  != 0) ? 2'b11 : 2'b00;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          boot_q, boot_d;
  logic [3:0]    sh_tens_q, sh_tens_d, sh_ones_q, sh_ones_d;
  logic [3:0]    act_tens_q, act_tens_d, act_ones_q, act_ones_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          fd_q, fd_d;

  logic          enter_ones;
  logic [3:0]    digit;
  logic [6:0]    pat;
  logic [6:0]    seg_hi;
  logic [1:0]    an_hi;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - CW'(1);
    boot_d     = 1'b0;
    enter_ones = 1'b0;
    fd_d       = 1'b0;
    if (boot_q) begin
      cnt_d      = BOOT_RLD;
      enter_ones = 1'b1;
    end else if (cnt_q == '0) begin
      case (state_q)
        S_ONES: begin
          if (GAP_CYCLES == 0) begin
            state_d = S_TENS;
            cnt_d   = SLOT_RLD;
          end else begin
            state_d = S_GAP1;
            cnt_d   = GAP_RLD;
          end
        end
        S_GAP1: begin
          state_d = S_TENS;
          cnt_d   = SLOT_RLD;
        end
        S_TENS: begin
          if (GAP_CYCLES == 0) begin
            state_d    = S_ONES;
            cnt_d      = SLOT_RLD;
            enter_ones = 1'b1;
            fd_d       = 1'b1;
          end else begin
            state_d = S_GAP0;
            cnt_d   = GAP_RLD;
          end
        end
        default: begin
          state_d    = S_ONES;
          cnt_d      = SLOT_RLD;
          enter_ones = 1'b1;
          fd_d       = 1'b1;
        end
      endcase
    end
  end

  // Shadow keeps the latest load; the active pair only changes at a frame
  // boundary so both digits always come from one load. A load on the
  // boundary edge bypasses the shadow.
  always_comb begin
    sh_tens_d  = bus.load ? bus.tens : sh_tens_q;
    sh_ones_d  = bus.load ? bus.ones : sh_ones_q;
    act_tens_d = act_tens_q;
    act_ones_d = act_ones_q;
    if (enter_ones) begin
      act_tens_d = sh_tens_d;
      act_ones_d = sh_ones_d;
    end
  end

  assign digit = (state_q == S_TENS) ? act_tens_q : act_ones_q;

  bcd_to_seg7 u_dec (
    .digit (digit),
    .seg   (pat)
  );

  always_comb begin
    seg_hi = SEG_OFF;
    an_hi  = 2'b00;
    case (state_q)
      S_ONES: begin
        seg_hi = pat;
        an_hi  = 2'b01;
      end
      S_TENS: begin
        if (!(bus.blank_lz && (act_tens_q == 4'd0))) begin
          seg_hi = pat;
          an_hi  = 2'b10;
        end
      end
      default: begin
        seg_hi = SEG_OFF;
        an_hi  = 2'b00;
      end
    endcase
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    an_d  = (AN_ACTIVE_LOW  != 0) ? ~an_hi  : an_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ONES;
      cnt_q      <= '0;
      boot_q     <= 1'b1;
      sh_tens_q  <= 4'd0;
      sh_ones_q  <= 4'd0;
      act_tens_q <= 4'd0;
      act_ones_q <= 4'd0;
      seg_q      <= SEG_IDLE;
      an_q       <= AN_IDLE;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      boot_q     <= boot_d;
      sh_tens_q  <= sh_tens_d;
      sh_ones_q  <= sh_ones_d;
      act_tens_q <= act_tens_d;
      act_ones_q <= act_ones_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb/tb_bcd_seg7_scan.sv - directed bench for bcd_seg7_scan
module tb_bcd_seg7_scan;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bcd_seg7_scan_if dut_if ();

  bcd_seg7_scan #(
    .REFRESH_DIV    (4),
    .GAP_CYCLES     (2),
    .SEG_ACTIVE_LOW (1),
    .AN_ACTIVE_LOW  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] P_OFF  = 7'h7F;
  localparam logic [6:0] P_0    = 7'b1000000;
  localparam logic [6:0] P_1    = 7'b1111001;
  localparam logic [6:0] P_2    = 7'b0100100;
  localparam logic [6:0] P_3    = 7'b0110000;
  localparam logic [6:0] P_4    = 7'b0011001;
  localparam logic [6:0] P_5    = 7'b0010010;
  localparam logic [6:0] P_6    = 7'b0000010;
  localparam logic [6:0] P_7    = 7'b1111000;
  localparam logic [6:0] P_DASH = 7'b0111111;

  task automatic check(input string tag, input int ph,
                       input logic [6:0] exp_seg, input logic [1:0] exp_an,
                       input logic exp_fd);
    n_cmp++;
    assert (dut_if.seg === exp_seg) else begin
      n_bad++;
      $error("FAIL %s p%0d seg got %b want %b", tag, ph, dut_if.seg, exp_seg);
    end
    n_cmp++;
    assert (dut_if.an === exp_an) else begin
      n_bad++;
      $error("FAIL %s p%0d an got %b want %b", tag, ph, dut_if.an, exp_an);
    end
    n_cmp++;
    assert (dut_if.frame_done === exp_fd) else begin
      n_bad++;
      $error("FAIL %s p%0d frame_done got %b want %b", tag, ph, dut_if.frame_done, exp_fd);
    end
  endtask

  // One 12-cycle frame, checked at each falling edge. Optionally pulses
  // load for one edge, driven at the falling edge of phase ld_ph.
  task automatic run_frame(input string tag,
                           input logic [6:0] ones_seg, input logic [6:0] tens_seg,
                           input logic [1:0] tens_an,
                           input bit ld, input int ld_ph,
                           input logic [3:0] ld_tens, input logic [3:0] ld_ones);
    for (int p = 0; p < 12; p++) begin
      @(posedge clk);
      @(negedge clk);
      dut_if.load = 1'b0;
      if (p < 4)       check(tag, p, ones_seg, 2'b10, 1'b0);
      else if (p < 6)  check(tag, p, P_OFF, 2'b11, 1'b0);
      else if (p < 10) check(tag, p, tens_seg, tens_an, 1'b0);
      else             check(tag, p, P_OFF, 2'b11, p == 11);
      if (ld && p == ld_ph) begin
        dut_if.load = 1'b1;
        dut_if.tens = ld_tens;
        dut_if.ones = ld_ones;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    dut_if.load     = 1'b0;
    dut_if.tens     = 4'd0;
    dut_if.ones     = 4'd0;
    dut_if.blank_lz = 1'b0;

    repeat (3) @(negedge clk);
    check("reset", 0, P_OFF, 2'b11, 1'b0);
    rst_n = 1'b1;

    run_frame("boot", P_0, P_0, 2'b01, 1'b1, 2, 4'd1, 4'd2);
    run_frame("scan12_a", P_2, P_1, 2'b01, 1'b0, 0, 4'd0, 4'd0);
    // load on the boundary edge itself goes straight to the active pair
    run_frame("scan12_b", P_2, P_1, 2'b01, 1'b1, 10, 4'd0, 4'd7);
    dut_if.blank_lz = 1'b1;
    run_frame("lz_blank", P_7, P_OFF, 2'b11, 1'b0, 0, 4'd0, 4'd0);
    dut_if.blank_lz = 1'b0;
    run_frame("lz_show", P_7, P_0, 2'b01, 1'b1, 3, 4'hA, 4'hF);
    run_frame("invalid", P_DASH, P_DASH, 2'b01, 1'b1, 0, 4'd3, 4'd4);
    // new pair loaded during the tens slot must wait for the next frame
    run_frame("coh_34", P_4, P_3, 2'b01, 1'b1, 6, 4'd5, 4'd6);
    run_frame("coh_56", P_6, P_5, 2'b01, 1'b0, 0, 4'd0, 4'd0);

    for (int p = 0; p < 8; p++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst", 7, P_5, 2'b01, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 0, P_OFF, 2'b11, 1'b0);
    @(negedge clk);
    check("rst_hold", 1, P_OFF, 2'b11, 1'b0);
    rst_n = 1'b1;
    run_frame("after_rst", P_0, P_0, 2'b01, 1'b0, 0, 4'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
